monster_wave_ctrl: RTL

//  Responder side of the level handshake: accepts level_in from the game FSM, then runs one monster wave.
//  - Owns the monster alive mask, formation position/direction and tank lives.
//  - Reports win / tank_destroyed back to the game FSM as held levels.
//  - Sits beside the renderer; the renderer consumes alive_mask/form_x/form_y.

---
 rtl/space_monsters_pkg.sv | 41 ++++
 rtl/formation_mover.sv | 85 ++++++++
 rtl/monster_wave_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/space_monsters_pkg.sv
// Shared constants for the monster wave: state codes, level codes, screen bounds,
// and the move-period table.
package space_monsters_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned LVL_W    = 3;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned PERIOD_W = 3;

  localparam int unsigned NUM_MON_DEF = 8;
  localparam int unsigned LIVES_DEF   = 3;
  localparam int unsigned X_MIN       = 160;
  localparam int unsigned X_MAX       = 600;
  localparam int unsigned STEP_X      = 4;
  localparam int unsigned STEP_Y      = 16;
  localparam int unsigned Y_START     = 40;
  localparam int unsigned Y_LIMIT     = 400;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] ST_RUN  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WON  = 3'd3;
  localparam logic [STATE_W-1:0] ST_LOST = 3'd4;

  localparam logic [LVL_W-1:0] LVL_IDLE = 3'd0;
  localparam logic [LVL_W-1:0] LVL_1    = 3'd1;
  localparam logic [LVL_W-1:0] LVL_2    = 3'd2;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Frames per formation move; faster at higher levels.
  function automatic logic [PERIOD_W-1:0] period_for(input logic [LVL_W-1:0] lvl);
    case (lvl)
      LVL_1:   return 3'd4;
      LVL_2:   return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/formation_mover.sv
// Formation position stepper: frame divider, horizontal march and edge-bounce drop.
module formation_mover
  import space_monsters_pkg::*;
#(
  parameter int unsigned P_X_MIN   = X_MIN,
  parameter int unsigned P_X_MAX   = X_MAX,
  parameter int unsigned P_STEP_X  = STEP_X,
  parameter int unsigned P_STEP_Y  = STEP_Y,
  parameter int unsigned P_Y_START = Y_START
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                tick,
  input  logic [PERIOD_W-1:0] period,
  output logic [COORD_W-1:0]  form_x,
  output logic [COORD_W-1:0]  form_y,
  output logic [COORD_W-1:0]  form_y_nxt_c
);

  localparam logic [COORD_W-1:0] XMIN_W  = COORD_W'(P_X_MIN);
  localparam logic [COORD_W-1:0] XMAX_W  = COORD_W'(P_X_MAX);
  localparam logic [COORD_W-1:0] STEPX_W = COORD_W'(P_STEP_X);
  localparam logic [COORD_W-1:0] STEPY_W = COORD_W'(P_STEP_Y);
  localparam logic [COORD_W-1:0] YST_W   = COORD_W'(P_Y_START);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic                dir_q, dir_d;

  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    if (init) begin
      cnt_d = '0;
      x_d   = XMIN_W;
      y_d   = YST_W;
      dir_d = DIR_RIGHT;
    end else if (tick) begin
      if (cnt_q >= period - 3'd1) begin
        cnt_d = '0;
        // At an edge the formation drops and reverses instead of stepping sideways.
        if (dir_q == DIR_RIGHT) begin
          if (x_q + STEPX_W > XMAX_W) begin
            dir_d = DIR_LEFT;
            y_d   = y_q + STEPY_W;
          end else begin
            x_d = x_q + STEPX_W;
          end
        end else begin
          if (x_q < XMIN_W + STEPX_W) begin
            dir_d = DIR_RIGHT;
            y_d   = y_q + STEPY_W;
          end else begin
            x_d = x_q - STEPX_W;
          end
        end
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      x_q   <= XMIN_W;
      y_q   <= YST_W;
      dir_q <= DIR_RIGHT;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
      y_q   <= y_d;
      dir_q <= dir_d;
    end
  end

  assign form_x       = x_q;
  assign form_y       = y_q;
  assign form_y_nxt_c = y_d;

endmodule

// File: rtl/monster_wave_ctrl.sv
// Monster wave controller: level handshake FSM, alive mask, tank lives and
// win/lose reporting; formation movement lives in formation_mover.
module monster_wave_ctrl
  import space_monsters_pkg::*;
#(
  parameter int unsigned NUM_MON = NUM_MON_DEF,
  parameter int unsigned LIVES   = LIVES_DEF,
  localparam int unsigned IDX_W  = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LVL_W-1:0]   level_in,
  input  logic               frame_tick,
  input  logic               mon_hit,
  input  logic [IDX_W-1:0]   mon_hit_idx,
  input  logic               tank_hit,
  output logic [NUM_MON-1:0] alive_mask,
  output logic [COORD_W-1:0] form_x,
  output logic [COORD_W-1:0] form_y,
  output logic [1:0]         lives,
  output logic               win,
  output logic               tank_destroyed
);

  localparam logic [COORD_W-1:0] YLIM_W = COORD_W'(Y_LIMIT);

  logic [STATE_W-1:0] state_q, state_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [NUM_MON-1:0] alive_q, alive_d;
  logic [1:0]         lives_q, lives_d;
  logic               win_q, win_d;
  logic               lost_q, lost_d;
  logic               mover_init_c;
  logic               tick_en_c;
  logic [COORD_W-1:0] form_y_nxt_c;

  formation_mover u_mover (
    .clk          (clk),
    .rst          (rst),
    .init         (mover_init_c),
    .tick         (tick_en_c),
    .period       (period_for(lvl_q)),
    .form_x       (form_x),
    .form_y       (form_y),
    .form_y_nxt_c (form_y_nxt_c)
  );

  always_comb begin
    state_d      = state_q;
    lvl_d        = lvl_q;
    alive_d      = alive_q;
    lives_d      = lives_q;
    mover_init_c = 1'b0;
    tick_en_c    = 1'b0;
    if (level_in == LVL_IDLE) begin
      state_d = ST_IDLE;
      lvl_d   = LVL_IDLE;
      alive_d = '0;
      lives_d = '0;
    end else if (level_in != lvl_q) begin
      state_d = ST_LOAD;
      lvl_d   = level_in;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_LOAD: begin
          state_d      = ST_RUN;
          alive_d      = '1;
          lives_d      = 2'(LIVES);
          mover_init_c = 1'b1;
        end
        ST_RUN: begin
          tick_en_c = frame_tick;
          if (mon_hit && (32'(mon_hit_idx) < NUM_MON)) begin
            alive_d[mon_hit_idx] = 1'b0;
          end
          if (tank_hit && (lives_q != 2'd0)) begin
            lives_d = lives_q - 2'd1;
          end
          // Win beats lose when both end conditions land in the same cycle.
          if (alive_d == '0) begin
            state_d = ST_WON;
          end else if ((lives_d == 2'd0) || (form_y_nxt_c >= YLIM_W)) begin
            state_d = ST_LOST;
          end
        end
        ST_WON:  state_d = ST_WON;
        ST_LOST: state_d = ST_LOST;
        default: state_d = ST_IDLE;
      endcase
    end
    win_d  = (state_d == ST_WON);
    lost_d = (state_d == ST_LOST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lvl_q   <= LVL_IDLE;
      alive_q <= '0;
      lives_q <= '0;
      win_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      alive_q <= alive_d;
      lives_q <= lives_d;
      win_q   <= win_d;
      lost_q  <= lost_d;
    end
  end

  assign alive_mask     = alive_q;
  assign lives          = lives_q;
  assign win            = win_q;
  assign tank_destroyed = lost_q;

endmodule
